hs32_sram_arbiter: RTL

- Shares one sky130 1RW SRAM macro port (256x32, active-low csb/web, 4-bit byte wmask) between the hs32 CPU memory port and the management SoC Wishbone slave.
- Sequences each access as a registered command, a macro capture cycle, and a data/ack cycle.
- Arbitrates with fixed CPU priority, plus optional starvation protection for Wishbone.
- Sits between hs32_core1 and each SRAM macro instance in user_project_wrapper; one instance per macro.

---
 rtl/hs32_sram_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hs32_sram_arbiter.sv
// hs32_sram_arbiter: shares one sky130 1RW SRAM macro port (2^AW x 32) between
// the hs32 CPU memory port and the management SoC Wishbone slave.
// Each access runs IDLE -> CMD -> CAPT -> RESP; all macro pins are registered.
// Optional build macro HS32_SRAM_ARB_STARVE_EN: after STARVE_MAX consecutive
// CPU grants taken while Wishbone was waiting, Wishbone wins the next IDLE.
// Undefined: strict CPU priority.
module hs32_sram_arbiter #(
    parameter int unsigned AW         = 8,
    parameter logic [31:0] WB_BASE    = 32'h3000_0000,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // hs32 CPU memory port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [3:0]    cpu_wmask,
    input  logic [31:0]   cpu_dtw,
    output logic          cpu_ack,
    output logic [31:0]   cpu_dtr,
    // Wishbone classic slave
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    // SRAM macro port 0
    output logic          sram_csb,
    output logic          sram_web,
    output logic [3:0]    sram_wmask,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    logic   grant_wb;   // current access belongs to Wishbone
    logic   op_we;      // current access is a write
    logic   wb_abort;   // Wishbone master dropped cyc mid-access

    logic wb_hit;
    logic pick_cpu;
    logic pick_wb;

    // Address bits [1:0] select bytes within a word and are covered by sel.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], STARVE_MAX[0]};

    // Wishbone request decode against this macro's aligned window
    assign wb_hit = wbs_cyc_i & wbs_stb_i
                  & (wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);

`ifdef HS32_SRAM_ARB_STARVE_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved  = wb_hit & (starve_cnt == CW'(STARVE_MAX));
    assign pick_wb  = wb_hit & (~cpu_req | starved);
    assign pick_cpu = cpu_req & ~pick_wb;

    // Count CPU grants made while Wishbone waits; clear when Wishbone wins or leaves
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!wb_hit || pick_wb) begin
                starve_cnt <= '0;
            end else if (pick_cpu) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
`else
    assign pick_wb  = wb_hit & ~cpu_req;
    assign pick_cpu = cpu_req;
`endif

    // Access sequencer: latches the winner, drives the macro, returns data and ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            grant_wb   <= 1'b0;
            op_we      <= 1'b0;
            wb_abort   <= 1'b0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= 4'h0;
            sram_addr  <= '0;
            sram_din   <= 32'h0;
            cpu_ack    <= 1'b0;
            wbs_ack_o  <= 1'b0;
            cpu_dtr    <= 32'h0;
            wbs_dat_o  <= 32'h0;
        end else begin
            cpu_ack   <= 1'b0;
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_cpu) begin
                        state      <= CMD;
                        grant_wb   <= 1'b0;
                        op_we      <= cpu_we;
                        wb_abort   <= 1'b0;
                        sram_csb   <= 1'b0;
                        sram_web   <= ~cpu_we;
                        sram_wmask <= cpu_we ? cpu_wmask : 4'hF;
                        sram_addr  <= cpu_addr;
                        sram_din   <= cpu_dtw;
                    end else if (pick_wb) begin
                        state      <= CMD;
                        grant_wb   <= 1'b1;
                        op_we      <= wbs_we_i;
                        wb_abort   <= 1'b0;
                        sram_csb   <= 1'b0;
                        sram_web   <= ~wbs_we_i;
                        sram_wmask <= wbs_we_i ? wbs_sel_i : 4'hF;
                        sram_addr  <= wbs_adr_i[AW+1:2];
                        sram_din   <= wbs_dat_i;
                    end
                end
                CMD: begin
                    // Macro captures the command at this edge; release the port.
                    state      <= CAPT;
                    sram_csb   <= 1'b1;
                    sram_web   <= 1'b1;
                    sram_wmask <= 4'h0;
                    if (grant_wb && !wbs_cyc_i) begin
                        wb_abort <= 1'b1;
                    end
                end
                CAPT: begin
                    state <= RESP;
                    if (grant_wb) begin
                        // An abandoned cycle completes at the macro but is never acked.
                        if (!wb_abort && wbs_cyc_i) begin
                            wbs_ack_o <= 1'b1;
                            if (!op_we) begin
                                wbs_dat_o <= sram_dout;
                            end
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!op_we) begin
                            cpu_dtr <= sram_dout;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
